// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchronizer, tick-based debounce,
// and per-channel press/release/hold/auto-repeat pulse generation.
module button_conditioner #(
  parameter int unsigned N_CH         = 5,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DB_TICKS     = 4,
  parameter int unsigned HOLD_TICKS   = 8,
  parameter int unsigned REPEAT_TICKS = 3,
  parameter int unsigned ACTIVE_LOW   = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,     // release pulse; "release" is a reserved word
  output logic [N_CH-1:0] hold,
  output logic [N_CH-1:0] rep
);

  localparam int unsigned DB_W   = $clog2(DB_TICKS + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int unsigned REP_W  = $clog2(REPEAT_TICKS + 1);
  localparam logic        INV    = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {RELEASED, PRESSED, HELD, REPEATING} state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [REP_W-1:0]       rep_cnt;
    logic                   level_q, press_q, rel_q, hold_q, rep_q;
    state_t                 state;
    logic                   s, mismatch, toggle, rise, fall;

    assign s        = sync_q[SYNC_STAGES-1];
    assign mismatch = (s != level_q);
    assign toggle   = tick && mismatch && (db_cnt == DB_W'(DB_TICKS - 1));
    assign rise     = toggle && !level_q;
    assign fall     = toggle && level_q;

    // Synchronizer runs every clock, independent of tick.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i] ^ INV};
    end

    // Stable-time debounce: any matching sample restarts the count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (tick) begin
        if (!mismatch) begin
          db_cnt <= '0;
        end else if (toggle) begin
          db_cnt  <= '0;
          level_q <= ~level_q;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    // Press/hold/repeat FSM; a level fall takes priority over any due pulse.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state    <= RELEASED;
        hold_cnt <= '0;
        rep_cnt  <= '0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
        hold_q   <= 1'b0;
        rep_q    <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        hold_q  <= 1'b0;
        rep_q   <= 1'b0;
        if (fall) begin
          state    <= RELEASED;
          rel_q    <= 1'b1;
          hold_cnt <= '0;
          rep_cnt  <= '0;
        end else if (rise) begin
          state    <= PRESSED;
          press_q  <= 1'b1;
          hold_cnt <= '0;
          rep_cnt  <= '0;
        end else if (tick) begin
          case (state)
            PRESSED: begin
              if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                hold_cnt <= HOLD_W'(HOLD_TICKS);
                hold_q   <= 1'b1;
                state    <= HELD;
              end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end
            end
            // HELD counts its first repeat tick on the same edge it leaves.
            HELD, REPEATING: begin
              if (!repeat_en[i]) begin
                state   <= HELD;
                rep_cnt <= '0;
              end else begin
                state <= REPEATING;
                if (rep_cnt == REP_W'(REPEAT_TICKS - 1)) begin
                  rep_q   <= 1'b1;
                  rep_cnt <= '0;
                end else begin
                  rep_cnt <= rep_cnt + REP_W'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign level[i] = level_q;
    assign press[i] = press_q;
    assign rel[i]   = rel_q;
    assign hold[i]  = hold_q;
    assign rep[i]   = rep_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulse events are queued
// with their due cycle when stimulus is driven, then matched every cycle.
module tb_button_conditioner;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_HOLD  = 2;
  localparam int K_REP   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [4:0] btn, ren;
  logic [4:0] level, press, rel, hold, rep;
  logic [3:0] btn_al, ren_al;
  logic [3:0] level_al, press_al, rel_al, hold_al, rep_al;

  int cyc      = 0;
  int mode     = 0;   // 0: tick always, 1: every 4th edge, 2: tick off
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int at; int dut; int kind; int ch; } ev_t;
  ev_t sb[$];

  logic [4:0] e_pulse [2][4];
  logic [4:0] e_lvl   [2];

  button_conditioner u_dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_in(btn), .repeat_en(ren),
    .level(level), .press(press), .rel(rel), .hold(hold), .rep(rep)
  );

  button_conditioner #(.N_CH(4), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .reset(reset), .tick(tick), .btn_in(btn_al), .repeat_en(ren_al),
    .level(level_al), .press(press_al), .rel(rel_al), .hold(hold_al), .rep(rep_al)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic ev(input int d, input int k, input int ch, input int at);
    ev_t e;
    e.at = at; e.dut = d; e.kind = k; e.ch = ch;
    sb.push_back(e);
  endtask

  task automatic set_tick();
    case (mode)
      0:       tick = 1'b1;
      1:       tick = ((cyc + 1) % 4 == 0);
      default: tick = 1'b0;
    endcase
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      set_tick();
    end
  endtask

  // Pop events due this cycle and compare every output of both instances.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) e_pulse[d][k] = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        e_pulse[sb[i].dut][sb[i].kind][sb[i].ch] = 1'b1;
        sb.delete(i);
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (reset) e_lvl[d] = '0;
      else e_lvl[d] = (e_lvl[d] | e_pulse[d][K_PRESS]) & ~e_pulse[d][K_REL];
    end
    check("d0_level", 32'(level), 32'(e_lvl[0]));
    check("d0_press", 32'(press), 32'(e_pulse[0][K_PRESS]));
    check("d0_rel",   32'(rel),   32'(e_pulse[0][K_REL]));
    check("d0_hold",  32'(hold),  32'(e_pulse[0][K_HOLD]));
    check("d0_rep",   32'(rep),   32'(e_pulse[0][K_REP]));
    check("d1_level", 32'(level_al), 32'(e_lvl[1]));
    check("d1_press", 32'(press_al), 32'(e_pulse[1][K_PRESS]));
    check("d1_rel",   32'(rel_al),   32'(e_pulse[1][K_REL]));
    check("d1_hold",  32'(hold_al),  32'(e_pulse[1][K_HOLD]));
    check("d1_rep",   32'(rep_al),   32'(e_pulse[1][K_REP]));
  end

  initial begin
    int d;
    logic [8:0] bounce;
    e_lvl[0] = '0;
    e_lvl[1] = '0;
    reset  = 1'b1;
    tick   = 1'b1;
    btn    = '0;
    ren    = 5'b00101;
    btn_al = 4'hF;
    ren_al = '0;
    step(3);
    reset = 1'b0;
    step(5);

    // Press, hold, repeats on ch0; release lands on a due repeat edge.
    d = cyc;
    btn[0] = 1'b1;
    ev(0, K_PRESS, 0, d + 6);
    ev(0, K_HOLD,  0, d + 14);
    ev(0, K_REP,   0, d + 17);
    ev(0, K_REP,   0, d + 20);
    ev(0, K_REP,   0, d + 23);
    step(20);
    btn[0] = 1'b0;
    ev(0, K_REL, 0, d + 26);
    step(12);

    // Short glitch on ch1 is rejected.
    btn[1] = 1'b1;
    step(3);
    btn[1] = 1'b0;
    step(10);

    // Bouncing input on ch1 (first value in bit 0): qualifies after final run of 1s.
    bounce = 9'b111101101;
    d = cyc;
    ev(0, K_PRESS, 1, d + 11);
    ev(0, K_HOLD,  1, d + 19);
    for (int j = 0; j < 9; j++) begin
      btn[1] = bounce[j];
      step(1);
    end
    step(15);
    d = cyc;
    btn[1] = 1'b0;
    ev(0, K_REL, 1, d + 6);
    step(10);

    // Tick every 4th edge on ch3, then a 100-clk freeze mid-hold count.
    while (cyc % 4 != 0) step(1);
    mode = 1;
    set_tick();
    d = cyc;
    btn[3] = 1'b1;
    ev(0, K_PRESS, 3, d + 16);
    ev(0, K_HOLD,  3, d + 148);
    step(28);
    mode = 2;
    set_tick();
    step(100);
    mode = 1;
    set_tick();
    step(24);
    mode = 0;
    set_tick();
    d = cyc;
    btn[3] = 1'b0;
    ev(0, K_REL, 3, d + 6);
    step(10);

    // Reset while ch2 is repeating; button held through reset re-qualifies.
    d = cyc;
    btn[2] = 1'b1;
    ev(0, K_PRESS, 2, d + 6);
    ev(0, K_HOLD,  2, d + 14);
    ev(0, K_REP,   2, d + 17);
    ev(0, K_REP,   2, d + 20);
    step(21);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    ev(0, K_PRESS, 2, d + 30);
    ev(0, K_HOLD,  2, d + 38);
    ev(0, K_REP,   2, d + 41);
    ev(0, K_REP,   2, d + 44);
    ev(0, K_REP,   2, d + 47);
    ev(0, K_REP,   2, d + 50);
    step(22);
    btn[2] = 1'b0;
    ev(0, K_REL, 2, d + 52);
    step(12);

    // Active-low instance: ch0 and ch3 pressed together.
    d = cyc;
    btn_al = 4'b0110;
    ev(1, K_PRESS, 0, d + 6);
    ev(1, K_PRESS, 3, d + 6);
    ev(1, K_HOLD,  0, d + 14);
    ev(1, K_HOLD,  3, d + 14);
    step(20);
    d = cyc;
    btn_al = 4'hF;
    ev(1, K_REL, 0, d + 6);
    ev(1, K_REL, 3, d + 6);
    step(12);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Multi-channel push-button conditioner for the alarm clock's user inputs. It replaces fixed shift-register debouncing with a per-channel synchronizer and a stable-time counter. Each channel produces a clean level plus single-cycle press, release, long-press (hold) and auto-repeat pulses. It sits between the board push-buttons and the mode/set FSMs, and is clocked by the system clock with a sampling strobe from the prescaler.

Parameters:
N_CH, 5, number of independent button channels
SYNC_STAGES, 2, synchronizer flops per channel (minimum 2)
DB_TICKS, 4, consecutive mismatching tick samples required to change the debounced level (minimum 1)
HOLD_TICKS, 8, ticks of continuous press before the hold pulse (minimum 1)
REPEAT_TICKS, 3, ticks between auto-repeat pulses after hold (minimum 1)
ACTIVE_LOW, 0, 1 = raw input is inverted before synchronization

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  sample-enable strobe; all debounce, hold and repeat counters advance only on clk edges where tick=1
btn_in  in  N_CH  raw asynchronous button inputs
repeat_en  in  N_CH  per-channel auto-repeat enable
level  out  N_CH  debounced pressed state (1 = pressed)
press  out  N_CH  one-clk pulse on a debounced 0->1 transition
release  out  N_CH  one-clk pulse on a debounced 1->0 transition
hold  out  N_CH  one-clk pulse when a press reaches HOLD_TICKS
rep  out  N_CH  one-clk auto-repeat pulses

Behaviour:
- Reset (async, active-high):
  - Synchronizer flops are cleared to the inactive value (0 after optional inversion).
  - All counters are cleared.
  - level, press, release, hold and rep all read 0 during reset and on the first clk after release.
- Synchronizer: SYNC_STAGES flops per channel, clocked every clk (not gated by tick). The synchronized sample s[i] is the last stage.
- Debounce counter db_cnt[i]:
  - Width is $clog2(DB_TICKS+1).
  - On a tick edge: if s[i]==level[i], db_cnt clears to 0; else db_cnt increments.
  - When a tick edge sees a mismatch with db_cnt==DB_TICKS-1, level[i] toggles and db_cnt clears.
  - A single matching sample restarts the count, so glitches shorter than DB_TICKS ticks never change level.
  - Non-tick edges leave db_cnt unchanged.
- Latency: with tick held at 1, level follows a clean input change after SYNC_STAGES+DB_TICKS clk edges.
- Edge pulses: press/release are registered and high for exactly one clk, in the first cycle level shows its new value.
- Per-channel FSM:
  - States: RELEASED, PRESSED, HELD, REPEATING.
  - RELEASED -> PRESSED on a level rise; hold_cnt clears.
  - PRESSED: hold_cnt increments on each tick edge. When hold_cnt reaches HOLD_TICKS, pulse hold and go to HELD.
  - HELD: if repeat_en[i]=1, go to REPEATING with rep_cnt=0. Otherwise stay and emit nothing further.
  - REPEATING: rep_cnt increments on tick. At REPEAT_TICKS, pulse rep and clear rep_cnt.
  - If repeat_en[i] drops while REPEATING, go to HELD; no further rep pulses until it returns high.
  - Any state -> RELEASED on a level fall; release pulses and all counters clear. A level fall wins over a hold/rep event due on the same edge; that pulse is suppressed.
  - Counters saturate and never wrap. Their widths are sized by $clog2(max+1) of the respective parameter.
- Timing of the first repeat: the first rep pulse occurs REPEAT_TICKS ticks after the hold pulse, counted from the hold edge. The HELD->REPEATING transition costs no tick.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses on the same cycle.
- tick=0 for any period: level and FSM states freeze; only the synchronizers move.
- Reset mid-operation: all state is lost. A button held through reset release re-qualifies as a fresh press after SYNC_STAGES+DB_TICKS ticked edges, and press pulses once.
- ACTIVE_LOW=1 inverts btn_in at the input. All outputs keep active-high meaning.

Test Plan:
- Defaults, tick=1, btn_in[0] 0->1 held: level[0] and press[0] go high 6 clks after the change, press for 1 clk. hold[0] pulses 8 clks after press. With repeat_en[0]=1, rep[0] pulses at +3, +6, +9 clks after hold.
- Glitches, tick=1: 3-clk high pulse on btn_in[1] -> no level/press change. Bouncing input 1,0,1,1,0,1,1,1,1 (1 clk each) -> level rises only after the final run of four 1s.
- Release: btn_in[0] 1->0 while REPEATING -> release[0] 1 clk, 6 clks later. No rep after level falls. A same-edge rep due is suppressed.
- Tick gating: tick pulses every 4th clk; press qualifies only after 4 ticked samples post-sync. Holding tick=0 for 100 clks leaves level and counters frozen.
- Reset while channel 2 is held and REPEATING: all outputs 0. After reset release with the button still held, press[2] pulses once after 6 clks (tick=1), and hold restarts from 0.
- ACTIVE_LOW=1, N_CH=4: drive channels 0 and 3 low on the same clk -> both press pulses on the same cycle. Channels 1 and 2 stay idle.
